uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Receive-side frame controller for the UART RX path. It runs at the oversampling clock, detects the start bit, and tracks the edge and bit counters. It deserialises the data sampler's sampled_bit into P_DATA and drives par_chk_en to the downstream parity checker, registering that checker's par_err result. It also checks the stop bit and issues a one-cycle data_valid for every clean frame.

Parameters:
DATA_WIDTH, 8, data bits per frame, sent LSB first
PRESCALE_W, 6, width of the Prescale and edge_cnt buses

Ports:
CLK  input  1  oversampling clock, one tick per sample
nRESET  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit
Prescale  input  6  oversamples per bit: 8, 16 or 32
sampled_bit  input  1  majority-voted bit from the data sampler
par_err  input  1  combinational result from the parity checker
dat_samp_en  output  1  enables the data sampler
edge_cnt  output  6  oversample index within the current bit
par_chk_en  output  1  enables the parity checker
P_DATA  output  8  received byte
data_valid  output  1  one-cycle pulse, P_DATA valid
par_err_flag  output  1  one-cycle pulse on parity error
stp_err  output  1  one-cycle pulse on stop-bit error
strt_glitch  output  1  one-cycle pulse on a false start

Behaviour:
- Reset (asynchronous, nRESET low):
  - state goes to IDLE; edge_cnt, bit_cnt and the shift register clear.
  - All outputs are 0.
  - A reset in the middle of a frame abandons the frame; no pulse is emitted.
- Frame configuration:
  - Prescale and PAR_EN are latched on start detect and held for the whole frame.
  - A latched Prescale outside {8,16,32} is treated as 8.
- "Last edge" means edge_cnt == Prescale_l-1. At the last edge, edge_cnt wraps to 0; otherwise it increments each CLK.
- The sampler guarantees sampled_bit is stable at the last edge.
- States:
  - IDLE: edge_cnt = 0. If RX_IN == 0, go to START and set edge_cnt <= 1; the detect cycle counts as edge 0.
  - START: at the last edge, sampled_bit == 1 pulses strt_glitch and returns to IDLE. Otherwise go to DATA with bit_cnt = 0.
  - DATA: at the last edge, shift in LSB-first: shreg <= {sampled_bit, shreg[7:1]}, then bit_cnt++. After bit 7, go to PARITY if PAR_EN_l, else STOP.
  - PARITY:
    - par_chk_en is high, combinationally, only during the last-edge cycle.
    - In that cycle, register par_err into a frame error bit and go to STOP.
    - P_DATA already holds the full byte at this point.
  - STOP: at the last edge, stop_bad = !sampled_bit, then go to IDLE.
- Frame outcome, registered and visible the cycle after the stop bit's last edge:
  - data_valid = !stop_bad && !par_err_r.
  - par_err_flag = par_err_r.
  - stp_err = stop_bad.
  - Each of these is exactly one cycle wide.
- The next frame's start bit is accepted the cycle after the stop decision; there are no dead ticks, so back-to-back frames work.
- dat_samp_en = (state != IDLE) || !RX_IN.
- P_DATA is driven from the shift register and updates only at DATA last edges. It holds its value after data_valid until the next frame's bit 0.
- Latency, counted from the start-detect cycle (cycle 0):
  - data_valid is high at cycle 10·Prescale without parity.
  - data_valid is high at cycle 11·Prescale with parity.
- RX_IN going high again mid-start is ignored except through sampled_bit; glitch detection uses the sampler result only.

Decomposition:
- uart_rx_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - the PRESCALE_8/16/32 constants;
  - the DATA_WIDTH default.
- Sub-module uart_rx_edge_bit_cnt holds the edge_cnt/bit_cnt counters with wrap and last-edge detect, and the Prescale latch.
- The FSM, deserialiser and error registers stay in uart_rx_fsm.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 with a good stop bit -> data_valid high for exactly cycle 80 after detect, P_DATA=0xA5, no error pulses.
2. Prescale=8, PAR_EN=1, even parity (checker wired), 0x3C with parity bit 0 -> data_valid at cycle 88. Repeat with parity bit 1 -> par_err_flag pulse at cycle 88 and no data_valid.
3. Prescale=16, RX_IN low for 3 ticks then high -> strt_glitch pulse at cycle 16, FSM back in IDLE, no data_valid.
4. Prescale=8, 0x5A with stop bit 0 -> stp_err pulse at cycle 80, data_valid stays 0.
5. Prescale=32, back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses 320 cycles apart, with P_DATA=0x00 then 0xFF.
6. nRESET asserted during DATA bit 4 -> all outputs 0 immediately. After release, a fresh 0x81 frame is received with data_valid and P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// the legal oversampling ratios and the default frame geometry.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  // Supported oversampling ratios; anything else falls back to 8.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Map a requested prescale onto a supported ratio.
  function automatic int legal_prescale(input int req);
    if (req == PRESCALE_16 || req == PRESCALE_32) begin
      return req;
    end
    return PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample (edge) and bit counters for the UART receiver.
// Latches the frame's prescale on start detect, wraps the edge counter
// at the last oversample of each bit and flags that last edge.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  start_det,
  input  logic                  in_frame,
  input  logic                  bit_clr,
  input  logic                  bit_inc,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  last_edge
);

  logic [PRESCALE_W-1:0] prescale_l;
  logic [PRESCALE_W-1:0] prescale_sel;

  // Sanitise the requested ratio before it is latched for the frame.
  always_comb begin
    prescale_sel = PRESCALE_W'(legal_prescale(int'(Prescale)));
  end

  // Prescale is captured once per frame, on the start-detect cycle.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      prescale_l <= PRESCALE_W'(PRESCALE_8);
    end else if (start_det) begin
      prescale_l <= prescale_sel;
    end
  end

  assign last_edge = in_frame && (edge_cnt == (prescale_l - PRESCALE_W'(1)));

  // Edge counter: the detect cycle is edge 0, so the first frame tick is 1.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      edge_cnt <= '0;
    end else if (start_det) begin
      edge_cnt <= PRESCALE_W'(1);
    end else if (in_frame) begin
      if (last_edge) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end else begin
      edge_cnt <= '0;
    end
  end

  // Bit counter indexes the data bits; cleared as the start bit ends.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Runs at the oversampling clock, detects
// the start bit, deserialises the sampler output LSB first, drives the
// parity checker enable and reports the frame outcome as one-cycle pulses.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low (start detect)
// START  | inside start bit; sampler high at last edge = false start
// DATA   | shifting in DATA_WIDTH bits, one per bit period
// PARITY | parity bit; checker enabled on the last edge, result latched
// STOP   | stop bit; frame outcome registered at the last edge
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sampled_bit,
  input  logic                  par_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err_flag,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_l;
  logic                  par_err_r;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  last_edge;
  logic                  start_det;
  logic                  in_frame;
  logic                  bit_clr;
  logic                  bit_inc;

  assign start_det = (state == IDLE) && !RX_IN;
  assign in_frame  = (state != IDLE);
  assign bit_clr   = (state == START) && last_edge;
  assign bit_inc   = (state == DATA) && last_edge;

  uart_rx_edge_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .start_det (start_det),
    .in_frame  (in_frame),
    .bit_clr   (bit_clr),
    .bit_inc   (bit_inc),
    .Prescale  (Prescale),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge)
  );

  // Sampler runs through the whole frame and already on the detect cycle;
  // gated by reset so every output reads 0 while reset is held.
  assign dat_samp_en = nRESET && (in_frame || !RX_IN);
  assign par_chk_en  = (state == PARITY) && last_edge;
  assign P_DATA      = shreg;

  // Frame sequencing, deserialiser and registered outcome pulses.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state        <= IDLE;
      shreg        <= '0;
      par_en_l     <= 1'b0;
      par_err_r    <= 1'b0;
      data_valid   <= 1'b0;
      par_err_flag <= 1'b0;
      stp_err      <= 1'b0;
      strt_glitch  <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      par_err_flag <= 1'b0;
      stp_err      <= 1'b0;
      strt_glitch  <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            par_en_l  <= PAR_EN;
            par_err_r <= 1'b0;
          end
        end
        START: begin
          if (last_edge) begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_edge) begin
            shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              state <= par_en_l ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_err_r <= par_err;
            state     <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            data_valid   <= sampled_bit && !par_err_r;
            par_err_flag <= par_err_r;
            stp_err      <= !sampled_bit;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm. Frames are described at the bit
// level (start, data LSB first, optional parity, stop) and the expected
// per-cycle behaviour is computed from bit position and prescale.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       sampled_bit;
  logic       par_err;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic       par_chk_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err_flag;
  logic       stp_err;
  logic       strt_glitch;

  int tests = 0;
  int fails = 0;

  // Outcome expected in the current cycle (set when a frame ends).
  logic [3:0] pend_pulses = 4'b0;
  logic [7:0] pend_data   = 8'h00;
  bit         pend_chk    = 1'b0;

  uart_rx_fsm dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .Prescale     (Prescale),
    .sampled_bit  (sampled_bit),
    .par_err      (par_err),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .par_chk_en   (par_chk_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err_flag (par_err_flag),
    .stp_err      (stp_err),
    .strt_glitch  (strt_glitch)
  );

  always #5 CLK = ~CLK;

  // Even-parity checker as wired downstream of the receiver.
  assign par_err = par_chk_en & (^P_DATA ^ sampled_bit);

  task automatic check_cycle(input int exp_edge, input bit exp_pchk, input bit exp_dse);
    logic [3:0] got_p;
    logic [1:0] got_e;
    logic [1:0] want_e;
    #1;
    got_p  = {data_valid, par_err_flag, stp_err, strt_glitch};
    got_e  = {par_chk_en, dat_samp_en};
    want_e = {exp_pchk, exp_dse};
    tests++;
    assert (got_p === pend_pulses) else begin
      fails++;
      $error("FAIL pulses(dv,pe,se,sg) got=%b want=%b t=%0t", got_p, pend_pulses, $time);
    end
    tests++;
    assert (edge_cnt === 6'(exp_edge)) else begin
      fails++;
      $error("FAIL edge_cnt got=%0d want=%0d t=%0t", edge_cnt, exp_edge, $time);
    end
    tests++;
    assert (got_e === want_e) else begin
      fails++;
      $error("FAIL enables(pchk,dse) got=%b want=%b t=%0t", got_e, want_e, $time);
    end
    if (pend_chk) begin
      tests++;
      assert (P_DATA === pend_data) else begin
        fails++;
        $error("FAIL P_DATA got=%h want=%h t=%0t", P_DATA, pend_data, $time);
      end
    end
    pend_pulses = 4'b0;
    pend_chk    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      RX_IN       = 1'b1;
      sampled_bit = 1'b1;
      check_cycle(0, 1'b0, 1'b0);
      @(posedge CLK); #1;
    end
  endtask

  // Drive one frame; cycle 0 is the start-detect cycle. abort_at >= 0
  // stops after that cycle's checks without recording an outcome.
  task automatic send_frame(input int p_drv, input bit pe, input logic [7:0] d,
                            input bit pb, input bit sb, input int abort_at,
                            input bit noise);
    int          p;
    int          nb;
    logic [10:0] bits;
    bit          perr;
    p  = (p_drv == 16 || p_drv == 32) ? p_drv : 8;
    nb = pe ? 11 : 10;
    bits      = 11'h7FF;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pe) bits[9] = pb;
    bits[nb-1] = sb;
    Prescale = 6'(p_drv);
    PAR_EN   = pe;
    for (int c = 0; c < nb * p; c++) begin
      if (c > 0) begin
        Prescale = 6'($urandom_range(0, 63));
        PAR_EN   = 1'($urandom_range(0, 1));
      end
      sampled_bit = bits[c / p];
      if (c > 0 && noise) RX_IN = 1'($urandom_range(0, 1));
      else                RX_IN = bits[c / p];
      check_cycle(c % p, pe && (c == 10 * p - 1), 1'b1);
      if (c == abort_at) return;
      @(posedge CLK); #1;
    end
    perr        = pe && (pb != ^d);
    pend_pulses = {sb && !perr, perr, !sb, 1'b0};
    pend_data   = d;
    pend_chk    = 1'b1;
  endtask

  // Start bit that the sampler reports as high at its last edge.
  task automatic glitch(input int p_drv, input int low_ticks);
    int p;
    p = (p_drv == 16 || p_drv == 32) ? p_drv : 8;
    Prescale = 6'(p_drv);
    PAR_EN   = 1'b0;
    for (int c = 0; c < p; c++) begin
      RX_IN       = (c < low_ticks) ? 1'b0 : 1'b1;
      sampled_bit = (c == p - 1) ? 1'b1 : RX_IN;
      check_cycle(c, 1'b0, 1'b1);
      @(posedge CLK); #1;
    end
    pend_pulses = 4'b0001;
  endtask

  logic [20:0] all_out;
  int          p_tab [8] = '{8, 16, 32, 8, 16, 0, 63, 20};

  initial begin
    nRESET      = 1'b0;
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    PAR_EN      = 1'b0;
    Prescale    = 6'd8;
    #1;
    all_out = {dat_samp_en, edge_cnt, par_chk_en, P_DATA, data_valid,
               par_err_flag, stp_err, strt_glitch};
    tests++;
    assert (all_out === 21'd0) else begin
      fails++;
      $error("FAIL reset_state got=%h want=0", all_out);
    end
    repeat (2) @(posedge CLK);
    #1;
    nRESET = 1'b1;
    idle(3);

    // Basic frame, no parity.
    send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b0);
    idle(2);
    // Parity good, then parity bad.
    send_frame(8, 1'b1, 8'h3C, 1'b0, 1'b1, -1, 1'b0);
    idle(2);
    send_frame(8, 1'b1, 8'h3C, 1'b1, 1'b1, -1, 1'b0);
    idle(2);
    // False start at prescale 16.
    glitch(16, 3);
    idle(3);
    // Bad stop bit.
    send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    // Back-to-back frames at prescale 32.
    send_frame(32, 1'b0, 8'h00, 1'b0, 1'b1, -1, 1'b0);
    send_frame(32, 1'b0, 8'hFF, 1'b0, 1'b1, -1, 1'b0);
    idle(2);
    // Unsupported prescale is treated as 8.
    send_frame(12, 1'b1, 8'hC3, 1'b0, 1'b1, -1, 1'b0);
    idle(2);

    // Reset during data bit 4 abandons the frame.
    send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b1, 5 * 8 + 3, 1'b0);
    RX_IN       = 1'b0;
    sampled_bit = 1'b0;
    nRESET      = 1'b0;
    #1;
    all_out = {dat_samp_en, edge_cnt, par_chk_en, P_DATA, data_valid,
               par_err_flag, stp_err, strt_glitch};
    tests++;
    assert (all_out === 21'd0) else begin
      fails++;
      $error("FAIL midframe_reset got=%h want=0", all_out);
    end
    repeat (3) @(posedge CLK);
    #1;
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    nRESET      = 1'b1;
    idle(4);
    send_frame(8, 1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0);
    idle(2);

    // Randomised frames with line noise and mid-frame config changes.
    for (int k = 0; k < 14; k++) begin
      int         pd;
      bit         pe;
      bit         pb;
      bit         sb;
      logic [7:0] d;
      int         gap;
      pd  = p_tab[$urandom_range(0, 7)];
      pe  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 2);
      send_frame(pd, pe, d, pb, sb, -1, 1'b1);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
